// File: rtl/mem_map_decoder.sv
// Registered 6809 memory-map decoder: CPU-programmable page regions,
// one-hot chip enables and per-channel MRDY wait-state stretching.
module mem_map_decoder #(
   parameter int                NUM_CH     = 8,
   parameter int                ADDR_W     = 16,
   parameter int                WS_W       = 3,
   parameter logic [ADDR_W-1:0] CFG_BASE   = 16'hA010,
   parameter logic [7:0]        BOOT_START = 8'h30,
   parameter logic [7:0]        BOOT_END   = 8'h3F,
   parameter logic [7:0]        BOOT_CTRL  = 8'h01
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_rw,
   input  logic              i_enable,
   input  logic              i_Q,
   input  logic [7:0]        i_data,
   output logic [7:0]        o_data,
   output logic              o_cfg_ce,
   output logic [NUM_CH-1:0] o_ce,
   output logic              o_mrdy
);

   localparam int                CH_W      = 4;
   localparam logic [7:0]        CTRL_MASK = 8'((1 << (WS_W + 2)) - 1);
   localparam logic [ADDR_W-1:0] WIN_SIZE  = ADDR_W'(4 * NUM_CH);

   logic [7:0]        start_q [NUM_CH];
   logic [7:0]        start_d [NUM_CH];
   logic [7:0]        end_q   [NUM_CH];
   logic [7:0]        end_d   [NUM_CH];
   logic [7:0]        ctrl_q  [NUM_CH];
   logic [7:0]        ctrl_d  [NUM_CH];
   logic [NUM_CH-1:0] ce_q, ce_d;
   logic              cfg_ce_q, cfg_ce_d;
   logic [7:0]        data_q, data_d;
   logic [WS_W-1:0]   cnt_q, cnt_d;
   logic              mrdy_q, mrdy_d;
   logic              e_q, e_d;

   logic [ADDR_W-1:0] offset;
   logic [CH_W-1:0]   cfg_ch;
   logic [1:0]        cfg_reg;
   logic [7:0]        page;
   logic [7:0]        rd_val;
   logic [WS_W-1:0]   ws_hit;
   logic              in_window;
   logic              bus_start;
   logic              wr_en;
   logic              hit_found;
   logic              hit_i;

   assign offset    = i_address - CFG_BASE;
   assign in_window = offset < WIN_SIZE;
   assign cfg_ch    = offset[CH_W+1:2];
   assign cfg_reg   = offset[1:0];
   assign page      = i_address[ADDR_W-1 -: 8];
   assign bus_start = i_enable & ~e_q;
   assign wr_en     = bus_start & ~i_rw & in_window &
                      ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
   assign e_d       = i_enable;

   // Lowest-index hit wins; the config window masks every channel.
   always_comb begin
      ce_d      = '0;
      ws_hit    = '0;
      hit_found = 1'b0;
      hit_i     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit_i = ctrl_q[i][0] &&
                 (start_q[i] <= page) && (page <= end_q[i]) &&
                 (ctrl_q[i][1] ? i_Q : i_enable);
         if (hit_i && !hit_found && !in_window) begin
            ce_d[i]   = 1'b1;
            ws_hit    = ctrl_q[i][WS_W+1:2];
            hit_found = 1'b1;
         end
      end
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            unique case (cfg_reg)
               2'd0:    rd_val = start_q[i];
               2'd1:    rd_val = end_q[i];
               2'd2:    rd_val = ctrl_q[i];
               default: rd_val = '0;
            endcase
         end
      end
      cfg_ce_d = i_enable & in_window;
      data_d   = cfg_ce_d ? rd_val : '0;
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         start_d[i] = start_q[i];
         end_d[i]   = end_q[i];
         ctrl_d[i]  = ctrl_q[i];
         if (wr_en && cfg_ch == CH_W'(i)) begin
            unique case (cfg_reg)
               2'd0:    start_d[i] = i_data;
               2'd1:    end_d[i]   = i_data;
               2'd2:    ctrl_d[i]  = i_data & CTRL_MASK;
               default: ;
            endcase
         end
      end
   end

   // Dropping E aborts any stretch in progress.
   always_comb begin
      cnt_d = cnt_q;
      if (!i_enable)
         cnt_d = '0;
      else if (bus_start)
         cnt_d = ws_hit;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
      mrdy_d = (cnt_q == '0) | ~i_enable;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            start_q[i] <= (i == 0) ? BOOT_START : 8'h00;
            end_q[i]   <= (i == 0) ? BOOT_END   : 8'h00;
            ctrl_q[i]  <= (i == 0) ? BOOT_CTRL  : 8'h00;
         end
         ce_q     <= '0;
         cfg_ce_q <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
         mrdy_q   <= 1'b1;
         e_q      <= 1'b1;
      end else begin
         start_q  <= start_d;
         end_q    <= end_d;
         ctrl_q   <= ctrl_d;
         ce_q     <= ce_d;
         cfg_ce_q <= cfg_ce_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         mrdy_q   <= mrdy_d;
         e_q      <= e_d;
      end
   end

   assign o_ce     = ce_q;
   assign o_cfg_ce = cfg_ce_q;
   assign o_data   = data_q;
   assign o_mrdy   = mrdy_q;

endmodule

// File: tb/tb_mem_map_decoder.sv
// Bench for mem_map_decoder: region-rule model checked every cycle,
// plus directed vectors with literal expectations.
module tb_mem_map_decoder;

   localparam int NCH  = 8;
   localparam int BASE = 'hA010;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic        rw;
   logic        en;
   logic        q;
   logic [7:0]  wdata;
   logic [7:0]  o_data;
   logic        o_cfg_ce;
   logic [7:0]  o_ce;
   logic        o_mrdy;

   int checks = 0;
   int errors = 0;

   mem_map_decoder dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_address (addr),
      .i_rw      (rw),
      .i_enable  (en),
      .i_Q       (q),
      .i_data    (wdata),
      .o_data    (o_data),
      .o_cfg_ce  (o_cfg_ce),
      .o_ce      (o_ce),
      .o_mrdy    (o_mrdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: regions as plain arrays, stretch as "edges since start <= WS".
   int m_start [NCH];
   int m_end   [NCH];
   int m_ctrl  [NCH];
   int prev_en, active, s_edge, s_ws, cyc;
   int e_ce, e_cfg, e_data, e_mrdy;
   bit valid = 0;

   always @(posedge clk) begin : model
      int a, pg, off, ch, r, first;
      bit in_win, bstart;
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            m_start[k] = (k == 0) ? 'h30 : 0;
            m_end[k]   = (k == 0) ? 'h3F : 0;
            m_ctrl[k]  = (k == 0) ? 'h01 : 0;
         end
         prev_en = 1; active = 0;
         e_ce = 0; e_cfg = 0; e_data = 0; e_mrdy = 1;
         valid = 1;
      end else begin
         a      = int'(addr);
         pg     = a / 256;
         in_win = (a >= BASE) && (a < BASE + 4 * NCH);
         off    = a - BASE;
         ch     = in_win ? off / 4 : 0;
         r      = in_win ? off % 4 : 0;
         e_cfg  = (en && in_win) ? 1 : 0;
         e_data = 0;
         if (e_cfg != 0) begin
            if (r == 0) e_data = m_start[ch];
            else if (r == 1) e_data = m_end[ch];
            else if (r == 2) e_data = m_ctrl[ch];
         end
         first = -1;
         if (!in_win)
            for (int k = 0; k < NCH; k++)
               if (first < 0 && (m_ctrl[k] % 2) == 1 &&
                   m_start[k] <= pg && pg <= m_end[k] &&
                   (((m_ctrl[k] / 2) % 2 == 1) ? q : en))
                  first = k;
         e_ce   = (first >= 0) ? (1 << first) : 0;
         bstart = en && (prev_en == 0);
         if (bstart) begin
            active = 0;
            if (first >= 0) begin
               s_ws   = (m_ctrl[first] / 4) % 8;
               s_edge = cyc;
               active = (s_ws > 0) ? 1 : 0;
            end
         end
         e_mrdy = (en && active != 0 && cyc - s_edge >= 1 &&
                   cyc - s_edge <= s_ws) ? 0 : 1;
         if (!en) active = 0;
         if (bstart && !rw && in_win) begin
            if (r == 0) m_start[ch] = int'(wdata);
            else if (r == 1) m_end[ch] = int'(wdata);
            else if (r == 2) m_ctrl[ch] = int'(wdata) % 32;
         end
         prev_en = en ? 1 : 0;
      end
      cyc++;
      #1;
      if (valid) begin
         chk("model_ce", 32'(o_ce), 32'(e_ce));
         chk("model_cfg_ce", 32'(o_cfg_ce), 32'(e_cfg));
         chk("model_data", 32'(o_data), 32'(e_data));
         chk("model_mrdy", 32'(o_mrdy), 32'(e_mrdy));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [15:0] a, input logic [7:0] d);
      addr = a; wdata = d; rw = 1'b0; en = 1'b1;
      tick();
      en = 1'b0; rw = 1'b1;
      tick();
   endtask

   task automatic cfg_read(input logic [15:0] a, input logic [7:0] exp,
                           input string name);
      addr = a; rw = 1'b1; en = 1'b1;
      tick();
      chk(name, 32'(o_data), 32'(exp));
      en = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; addr = '0; rw = 1'b1; en = 1'b0; q = 1'b0; wdata = '0;
      tick();
      tick();
      chk("rst_ce", 32'(o_ce), 32'h0);
      chk("rst_cfg_ce", 32'(o_cfg_ce), 32'h0);
      chk("rst_data", 32'(o_data), 32'h0);
      chk("rst_mrdy", 32'(o_mrdy), 32'h1);
      rst = 1'b0;
      tick();

      // boot channel
      addr = 16'h3000; en = 1'b1;
      tick();
      chk("boot_ce", 32'(o_ce), 32'h01);
      chk("boot_mrdy", 32'(o_mrdy), 32'h1);
      addr = 16'h1000;
      tick();
      chk("miss_ce", 32'(o_ce), 32'h00);
      en = 1'b0;
      tick();

      // ch1 programming and Q qualifier
      cfg_write(16'hA014, 8'h10);
      cfg_write(16'hA015, 8'h1F);
      cfg_write(16'hA016, 8'h03);
      cfg_read(16'hA014, 8'h10, "rd_ch1_start");
      cfg_read(16'hA015, 8'h1F, "rd_ch1_end");
      addr = 16'hA016; en = 1'b1;
      tick();
      chk("rd_ch1_ctrl", 32'(o_data), 32'h03);
      chk("rd_cfg_ce", 32'(o_cfg_ce), 32'h1);
      chk("rd_cfg_no_ce", 32'(o_ce), 32'h0);
      en = 1'b0;
      tick();
      addr = 16'h1234; q = 1'b1;
      tick();
      chk("q_ce", 32'(o_ce), 32'h02);
      q = 1'b0;
      tick();

      // overlapping ch2
      cfg_write(16'hA018, 8'h10);
      cfg_write(16'hA019, 8'h1F);
      cfg_write(16'hA01A, 8'h01);
      addr = 16'h1800; en = 1'b1; q = 1'b1;
      tick();
      chk("prio_ce", 32'(o_ce), 32'h02);
      q = 1'b0;
      tick();
      chk("ch2_only_ce", 32'(o_ce), 32'h04);
      en = 1'b0;
      tick();

      // ch3 with 5 wait states
      cfg_write(16'hA01C, 8'h40);
      cfg_write(16'hA01D, 8'h4F);
      cfg_write(16'hA01E, 8'h15);
      addr = 16'h4000; en = 1'b1;
      tick();
      chk("ws_start_mrdy", 32'(o_mrdy), 32'h1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("ws5_mrdy_%0d", k), 32'(o_mrdy),
             (k <= 5) ? 32'h0 : 32'h1);
      end
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      tick();
      tick();
      chk("abort_mrdy_low", 32'(o_mrdy), 32'h0);
      en = 1'b0;
      tick();
      chk("abort_mrdy", 32'(o_mrdy), 32'h1);
      tick();

      // reserved and out-of-range writes
      cfg_write(16'hA013, 8'hFF);
      cfg_read(16'hA013, 8'h00, "rd_reserved");
      cfg_read(16'hA010, 8'h30, "rd_ch0_start");
      cfg_read(16'hA011, 8'h3F, "rd_ch0_end");
      cfg_read(16'hA012, 8'h01, "rd_ch0_ctrl");
      cfg_write(16'hA030, 8'hFF);
      addr = 16'hA030; en = 1'b1;
      tick();
      chk("oor_cfg_ce", 32'(o_cfg_ce), 32'h0);
      chk("oor_data", 32'(o_data), 32'h0);
      en = 1'b0;
      tick();
      cfg_read(16'hA02C, 8'h00, "rd_ch7_start");
      cfg_read(16'hA02E, 8'h00, "rd_ch7_ctrl");

      // long E with changing data: first edge wins
      addr = 16'hA01C; rw = 1'b0; wdata = 8'h50; en = 1'b1;
      tick();
      for (int k = 0; k < 9; k++) begin
         wdata = 8'(8'h51 + k);
         tick();
      end
      en = 1'b0; rw = 1'b1;
      tick();
      cfg_read(16'hA01C, 8'h50, "rd_first_edge");

      // CTRL masking, then reset during a 7-clock stretch
      cfg_write(16'hA022, 8'hFF);
      cfg_read(16'hA022, 8'h1F, "rd_ctrl_mask");
      addr = 16'h0000; en = 1'b1; q = 1'b1;
      tick();
      chk("ws7_ce", 32'(o_ce), 32'h10);
      tick();
      tick();
      chk("ws7_mrdy", 32'(o_mrdy), 32'h0);
      rst = 1'b1;
      tick();
      chk("midrst_mrdy", 32'(o_mrdy), 32'h1);
      chk("midrst_ce", 32'(o_ce), 32'h0);
      en = 1'b0; q = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      for (int c = 1; c < NCH; c++)
         for (int r = 0; r < 3; r++)
            cfg_read(16'(BASE + 4 * c + r), 8'h00,
                     $sformatf("rst_ch%0d_reg%0d", c, r));
      cfg_read(16'hA010, 8'h30, "rst_ch0_start");
      cfg_read(16'hA012, 8'h01, "rst_ch0_ctrl");
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_map_decoder.md
# mem_map_decoder

Parametrised, registered successor to the fixed 6809 address decoder. It sits between the 6809 address bus and the chip-select inputs of SRAM, SPI flash, UART and future peripherals. Up to NUM_CH regions are defined at 256-byte page granularity in CPU-writable configuration registers, and a per-channel wait-state counter drives the 6809 MRDY line to stretch slow accesses. Channel 0 is preloaded at reset so the boot flash is reachable before software programs the map.

## Interface
- NUM_CH, 8: number of decoded channels (1..16)
- ADDR_W, 16: CPU address width; page = address[ADDR_W-1:ADDR_W-8]
- WS_W, 3: wait-state field width (0..7 clocks)
- CFG_BASE, 16'hA010: base of the config window; window size 4*NUM_CH bytes
- BOOT_START, 8'h30: channel 0 start page at reset
- BOOT_END, 8'h3F: channel 0 end page at reset
- BOOT_CTRL, 8'h01: channel 0 CTRL at reset (enabled, E-gated, 0 wait states)

Ports:
- i_clk, in, 1: system clock; the only clock
- i_reset, in, 1: synchronous, active-high reset
- i_address, in, ADDR_W: CPU address bus
- i_rw, in, 1: 1 = read, 0 = write
- i_enable, in, 1: 6809 E-phase qualifier
- i_Q, in, 1: 6809 Q-phase qualifier
- i_data, in, 8: CPU write data
- o_data, out, 8: config register read data
- o_cfg_ce, out, 1: config window selected; the top level drives the CPU bus from o_data when this is high
- o_ce, out, NUM_CH: one-hot channel chip enables; all zero when no channel hits
- o_mrdy, out, 1: 6809 MRDY; low stretches the bus cycle

## Operation
- Register map: offset = i_address - CFG_BASE; ch = offset[..:2]; reg = offset[1:0].
  - reg 0 = START page
  - reg 1 = END page
  - reg 2 = CTRL
  - reg 3 reserved: reads 0x00, writes ignored
- CTRL bits:
  - [0] enable
  - [1] qualifier select: 0 = i_enable, 1 = i_Q
  - [2+WS_W-1:2] wait-state count
  - remaining bits read back as 0
- Channel hit: enable=1, START <= page <= END, and the selected qualifier is high.
  - START > END means the channel never hits.
- Priority:
  - The config window overrides every channel: no o_ce bit is set while the config window is addressed.
  - Among overlapping channels, the lowest index wins. o_ce is never more than one-hot.
- Bus-cycle start: the first i_clk edge where i_enable=1 after a clock where i_enable was 0. A registered copy of i_enable provides the edge detect.
- Config write: accepted only at a bus-cycle start with i_rw=0, the address in the window, and ch < NUM_CH. Exactly one write is accepted per E cycle.
- Config read:
  - o_cfg_ce=1 and o_data = the selected register while i_enable=1 and the address is in the window.
  - Out-of-range channel or reg 3 returns 0x00.
  - o_data=0x00 when the window is not selected.
- Wait states:
  - At a bus-cycle start that hits channel k with WS>0, the counter loads WS.
  - o_mrdy is low while counter > 0; the counter decrements once per clock.
  - If i_enable falls while counting, the counter clears and o_mrdy returns high the next clock.
  - WS=0 never drops o_mrdy.
  - Config window accesses have 0 wait states.
- Reset values:
  - o_ce=0, o_cfg_ce=0, o_data=0x00, o_mrdy=1, counter=0
  - channel 0 = {BOOT_START, BOOT_END, BOOT_CTRL}
  - channels 1..NUM_CH-1 = {0x00, 0x00, 0x00}
- Reset mid-cycle: all outputs take their reset values on the next edge. No pending write is committed.

## Timing
- o_ce, o_cfg_ce and o_data are registered: each reflects the address and qualifier sampled at the previous i_clk edge (latency 1 clock).
- A config write is sampled at bus-cycle start edge N. The new value affects decode from edge N+1.
- Wait states: for a bus-cycle start at edge N with WS=w, o_mrdy is low after edges N+1..N+w and high after edge N+w+1.
- Simultaneous write to channel k's CTRL while channel k is hit: the current cycle's wait count uses the old CTRL value.
- Address change with the qualifier high: o_ce follows one clock later. There is no glitch because the outputs are registered.

## Test plan
- Reset, then read page 0x30 with i_enable=1 → o_ce=0x01 one clock later, o_mrdy stays 1; page 0x10 → o_ce=0x00.
- Write ch1 START=0x10, END=0x1F, CTRL=0x03 at 0xA014..0xA016 → readback returns 0x10, 0x1F, 0x03. Address 0x1234 with i_Q=1 and i_enable=0 → o_ce=0x02.
- Set ch2 to 0x10..0x1F enabled and ch1 to the same range → address 0x1800 asserts only o_ce[1] (lowest index wins).
- Set ch3 CTRL WS=5, then start a bus cycle on its range → o_mrdy low for exactly 5 clocks starting 1 clock after the start edge. Repeat with i_enable dropped after 2 clocks → o_mrdy high 1 clock after the drop.
- Write 0xFF to 0xA013 (reg 3) and to an out-of-range channel → reads return 0x00 and no channel changes. Hold i_enable high for 10 clocks during a write with changing data → only the first-edge data is stored.
- Assert i_reset during a WS=7 stretch → o_mrdy=1 and o_ce=0 the next clock, and channel 1..7 registers read 0x00.
